// File: rtl/alu_operand_sequencer.sv
// Multicycle phase FSM driving ALU operand-A/B selects and ALU op for each instruction phase.
// Optional illegal-opcode trap: define ALU_SEQ_ILLEGAL_TRAP_EN to add the sticky illegal_op port.
module alu_operand_sequencer #(
  parameter int MEM_WAIT = 2,  // 1..15, and 2**CNT_W must exceed it
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alusrcb_sel,
  output logic       alusrca_sel,
  output logic [2:0] alu_op,
  output logic       ir_write,
  output logic       pc_write,
  output logic       br_eval,
  output logic       mem_req,
  output logic [2:0] phase,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic       instr_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC_R = 3'd3,
    S_EXEC_I = 3'd4,
    S_ADDR   = 3'd5,
    S_MEMW   = 3'd6,
    S_BRANCH = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  localparam logic [2:0] SRCB_REGB   = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_SEXT   = 3'b010;
  localparam logic [2:0] SRCB_SEXT_2 = 3'b011;
  localparam logic [2:0] SRCB_ZEXT   = 3'b100;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_WAIT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_wb;          // WB sub-phase, shares the IDLE encoding
  logic             w_next_wb;
  logic             r_trap;        // only ever set when the trap build is enabled
  logic             w_next_trap;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_opcode;
  logic             w_last;
  logic             w_enter;

  logic [2:0] w_srcb, r_srcb;
  logic       w_srca, r_srca;
  logic [2:0] w_aluop, r_aluop;
  logic       w_ir, r_ir;
  logic       w_pc, r_pc;
  logic       w_br, r_br;
  logic       w_mem, r_mem;
  logic       w_done, r_done;
  logic [2:0] r_phase;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic       r_illegal;
`endif

  assign w_last  = (r_cnt == LAST_CNT);
  assign w_enter = (w_next_state != r_state) || (w_next_wb != r_wb);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_wb     <= 1'b0;
      r_trap   <= 1'b0;
      r_cnt    <= '0;
      r_opcode <= '0;
    end else begin
      r_state <= w_next_state;
      r_wb    <= w_next_wb;
      r_trap  <= w_next_trap;
      // Cleared on every state entry, otherwise counts up and holds at the last value.
      if (w_enter)
        r_cnt <= '0;
      else if (!w_last)
        r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_DECODE)
        r_opcode <= opcode;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_wb    = 1'b0;
    w_next_trap  = r_trap;
    w_srcb       = SRCB_REGB;
    w_srca       = 1'b0;
    w_aluop      = ALU_ADD;
    w_ir         = 1'b0;
    w_pc         = 1'b0;
    w_br         = 1'b0;
    w_mem        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_trap) begin
          w_srcb  = SRCB_REGB;
          w_aluop = ALU_PASSB;
        end else if (r_wb) begin
          w_done       = 1'b1;
          w_next_state = S_FETCH;
        end else if (run) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        w_srcb = SRCB_FOUR;
        w_mem  = 1'b1;
        if (w_last) begin
          w_ir         = 1'b1;
          w_pc         = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        w_srcb = SRCB_SEXT_2;  // branch target PC + (imm << 2)
        case (opcode)
          OP_RTYPE:                 w_next_state = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: w_next_state = S_EXEC_I;
          OP_LW, OP_SW:             w_next_state = S_ADDR;
          OP_BEQ, OP_BNE:           w_next_state = S_BRANCH;
          default: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            w_next_state = S_IDLE;
            w_next_trap  = 1'b1;
`else
            w_done       = 1'b1;
            w_next_state = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC_R: begin
        w_srcb = SRCB_REGB;
        w_srca = 1'b1;
        case (funct)
          FN_ADD:  w_aluop = ALU_ADD;
          FN_SUB:  w_aluop = ALU_SUB;
          FN_AND:  w_aluop = ALU_AND;
          FN_OR:   w_aluop = ALU_OR;
          FN_SLT:  w_aluop = ALU_SLT;
          default: w_aluop = ALU_ADD;
        endcase
        w_next_state = S_IDLE;
        w_next_wb    = 1'b1;
      end
      S_EXEC_I: begin
        w_srca = 1'b1;
        case (r_opcode)
          OP_ANDI: begin w_srcb = SRCB_ZEXT; w_aluop = ALU_AND; end
          OP_ORI:  begin w_srcb = SRCB_ZEXT; w_aluop = ALU_OR;  end
          default: begin w_srcb = SRCB_SEXT; w_aluop = ALU_ADD; end
        endcase
        w_next_state = S_IDLE;
        w_next_wb    = 1'b1;
      end
      S_ADDR: begin
        w_srcb       = SRCB_SEXT;
        w_srca       = 1'b1;
        w_next_state = S_MEMW;
      end
      S_MEMW: begin
        w_mem = 1'b1;
        if (w_last) begin
          if (r_opcode == OP_SW) begin
            w_done       = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_IDLE;
            w_next_wb    = 1'b1;
          end
        end
      end
      S_BRANCH: begin
        w_srcb       = SRCB_REGB;
        w_srca       = 1'b1;
        w_aluop      = ALU_SUB;
        w_br         = 1'b1;
        w_done       = 1'b1;
        w_next_state = S_FETCH;
      end
    endcase
  end

  // Outputs reflect the state occupied during the previous cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_srcb    <= '0;
      r_srca    <= 1'b0;
      r_aluop   <= '0;
      r_ir      <= 1'b0;
      r_pc      <= 1'b0;
      r_br      <= 1'b0;
      r_mem     <= 1'b0;
      r_done    <= 1'b0;
      r_phase   <= '0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_srcb    <= w_srcb;
      r_srca    <= w_srca;
      r_aluop   <= w_aluop;
      r_ir      <= w_ir;
      r_pc      <= w_pc;
      r_br      <= w_br;
      r_mem     <= w_mem;
      r_done    <= w_done;
      r_phase   <= r_state;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      r_illegal <= r_illegal | r_trap;
`endif
    end
  end

  assign alusrcb_sel = r_srcb;
  assign alusrca_sel = r_srca;
  assign alu_op      = r_aluop;
  assign ir_write    = r_ir;
  assign pc_write    = r_pc;
  assign br_eval     = r_br;
  assign mem_req     = r_mem;
  assign instr_done  = r_done;
  assign phase       = r_phase;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign illegal_op  = r_illegal;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: per-instruction expected output streams from a phase-level model.
module tb_alu_operand_sequencer;

  localparam int MW = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [2:0] alusrcb_sel;
  logic       alusrca_sel;
  logic [2:0] alu_op;
  logic       ir_write;
  logic       pc_write;
  logic       br_eval;
  logic       mem_req;
  logic [2:0] phase;
  logic       instr_done;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic       illegal_op;
  localparam int NOPS = 8;
  localparam bit TRAP = 1'b1;
`else
  localparam int NOPS = 10;
  localparam bit TRAP = 1'b0;
`endif

  alu_operand_sequencer #(.MEM_WAIT(MW), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .alusrcb_sel(alusrcb_sel), .alusrca_sel(alusrca_sel), .alu_op(alu_op),
    .ir_write(ir_write), .pc_write(pc_write), .br_eval(br_eval),
    .mem_req(mem_req), .phase(phase),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .instr_done(instr_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [14:0] exp_q[$];
  logic [14:0] obs;

  assign obs = {phase, alusrcb_sel, alusrca_sel, alu_op,
                ir_write, pc_write, br_eval, mem_req, instr_done};

  logic [5:0] dir_op [0:10] = '{6'h00, 6'h0C, 6'h08, 6'h2B, 6'h23, 6'h04,
                                6'h05, 6'h0D, 6'h00, 6'h00, 6'h3F};
  logic [5:0] dir_fn [0:10] = '{6'h22, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h2A, 6'h3F, 6'h00};
  logic [5:0] rnd_ops [0:9] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B,
                                6'h04, 6'h05, 6'h3F, 6'h11};
  logic [5:0] rnd_fns [0:4] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  function automatic logic [14:0] vec(input logic [2:0] ph, input logic [2:0] srcb,
                                      input logic a, input logic [2:0] op,
                                      input logic ir, input logic pc, input logic br,
                                      input logic mem, input logic done);
    return {ph, srcb, a, op, ir, pc, br, mem, done};
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b001;
      6'h24:   return 3'b010;
      6'h25:   return 3'b011;
      6'h2A:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Reference model: the cycle-by-cycle output stream of one whole instruction.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn);
    logic [14:0] wb;
    logic [14:0] addr;
    wb   = vec(3'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    addr = vec(3'd5, 3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < MW; k++)
      exp_q.push_back(vec(3'd1, 3'b001, 1'b0, 3'b000, k == MW - 1, k == MW - 1, 1'b0, 1'b1, 1'b0));
    case (op)
      6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05:
        exp_q.push_back(vec(3'd2, 3'b011, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      default:
        exp_q.push_back(vec(3'd2, 3'b011, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, !TRAP));
    endcase
    case (op)
      6'h00: begin
        exp_q.push_back(vec(3'd3, 3'b000, 1'b1, ref_alu(fn), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(wb);
      end
      6'h08: begin
        exp_q.push_back(vec(3'd4, 3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(wb);
      end
      6'h0C: begin
        exp_q.push_back(vec(3'd4, 3'b100, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(wb);
      end
      6'h0D: begin
        exp_q.push_back(vec(3'd4, 3'b100, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(wb);
      end
      6'h23: begin
        exp_q.push_back(addr);
        for (int k = 0; k < MW; k++)
          exp_q.push_back(vec(3'd6, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(wb);
      end
      6'h2B: begin
        exp_q.push_back(addr);
        for (int k = 0; k < MW; k++)
          exp_q.push_back(vec(3'd6, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, k == MW - 1));
      end
      6'h04, 6'h05:
        exp_q.push_back(vec(3'd7, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [14:0] o, input logic [14:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    logic [14:0] e;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic start_run();
    run = 1'b1;
    step();
    check("idle_exit", obs, 15'h0);
    run = 1'b0;
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    model_instr(op, fn);
    drain(tag);
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    logic [14:0] e;
    reset  = 1'b0;
    run    = 1'b0;
    opcode = 6'h00;
    funct  = 6'h00;
    #1;
    check("reset_state", obs, 15'h0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_hold", obs, 15'h0);
    end

    start_run();
    for (int i = 0; i < 11; i++) begin
      if (TRAP && dir_op[i] == 6'h3F) continue;
      do_instr("directed", dir_op[i], dir_fn[i]);
    end

    // Random traffic, with run toggled to show it is ignored once running.
    for (int i = 0; i < 50; i++) begin
      op = rnd_ops[$urandom_range(0, NOPS - 1)];
      fn = ($urandom_range(0, 1) == 0) ? rnd_fns[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      run = 1'($urandom_range(0, 1));
      do_instr("random", op, fn);
    end
    run = 1'b0;

    // Asynchronous reset in the middle of a load's memory wait.
    opcode = 6'h23;
    funct  = 6'h00;
    model_instr(6'h23, 6'h00);
    for (int k = 0; k < MW + 3; k++) begin
      step();
      e = exp_q.pop_front();
      check("lw_pre_reset", obs, e);
    end
    exp_q.delete();
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_memw", obs, 15'h0);
    step();
    check("reset_held", obs, 15'h0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("idle_after_reset", obs, 15'h0);
    end
    start_run();
    do_instr("post_reset_sw", 6'h2B, 6'h00);
    do_instr("post_reset_beq", 6'h04, 6'h00);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    do_instr("trap_entry", 6'h3F, 6'h00);
    for (int i = 0; i < 4; i++) begin
      run = 1'($urandom_range(0, 1));
      step();
      check("trap_hold", obs, vec(3'd0, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("illegal_sticky", {14'h0, illegal_op}, 15'h1);
    end
    reset = 1'b0;
    #1;
    check("illegal_cleared", {14'h0, illegal_op}, 15'h0);
    reset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Multicycle control slice that drives the 3-bit ALU operand-B mux select, the operand-A select, and the ALU op for every instruction phase.
- Sits between the instruction register (opcode/funct) and the datapath muxes.
- Owns the fetch/decode/execute phase FSM. Counts memory wait cycles in fetch and in load/store address phases.

Parameters:
- MEM_WAIT, 2: memory access latency in cycles, range 1..15. Applies to the fetch wait and the lw/sw wait.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > MEM_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  allows leaving IDLE; sampled only in IDLE
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; used only for R-type
- alusrcb_sel  out  3  operand-B mux select. 000 regB, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 zero-ext imm
- alusrca_sel  out  1  0 = PC, 1 = regA
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 111 pass-B
- ir_write  out  1  one-cycle pulse, last fetch cycle
- pc_write  out  1  one-cycle pulse, last fetch cycle
- br_eval  out  1  high in BRANCH state
- mem_req  out  1  high throughout FETCH and MEMW
- phase  out  3  current state encoding, for debug
- instr_done  out  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all outputs 0.
- Outputs are registered, one cycle behind state entry.
- Unlisted outputs default to 0.
- States and encodings:
  - IDLE (0): wait for run=1, then go to FETCH.
  - FETCH (1): alusrca_sel=0, alusrcb_sel=001, alu_op=add, mem_req=1. Counter counts 0..MEM_WAIT-1. On the final count, pulse ir_write and pc_write, then go to DECODE.
  - DECODE (2): alusrca_sel=0, alusrcb_sel=011, alu_op=add (branch target). One cycle. Dispatch on opcode:
    - 0x00 → EXEC_R
    - 0x08 (addi) → EXEC_I
    - 0x0C (andi) → EXEC_I
    - 0x0D (ori) → EXEC_I
    - 0x23 (lw) → ADDR
    - 0x2B (sw) → ADDR
    - 0x04 (beq) → BRANCH
    - 0x05 (bne) → BRANCH
    - anything else → ILLEGAL handling (see Optional Feature)
  - EXEC_R (3): sel=000, alusrca_sel=1. alu_op from funct:
    - 0x20 → add
    - 0x22 → sub
    - 0x24 → and
    - 0x25 → or
    - 0x2A → slt
    - other → add
    - Next: WB.
  - EXEC_I (4): alusrca_sel=1.
    - addi: sel=010, alu_op=add
    - andi: sel=100, alu_op=and
    - ori: sel=100, alu_op=or
    - Next: WB.
  - ADDR (5): sel=010, alusrca_sel=1, alu_op=add. Next: MEMW.
  - MEMW (6): mem_req=1 for MEM_WAIT cycles.
    - sw: pulse instr_done on the final cycle, then go to FETCH.
    - lw: go to WB.
  - BRANCH (7): sel=000, alusrca_sel=1, alu_op=sub, br_eval=1. One cycle. Pulse instr_done, then go to FETCH.
  - WB: a 1-cycle sub-phase sharing encoding 0 with IDLE, distinguished by an internal flag. Pulse instr_done, then go to FETCH.
- run is ignored outside IDLE. The machine never returns to IDLE except by reset.
- Counter clears on every state entry and never wraps: it saturates at MEM_WAIT-1 until the exit transition.
- Reset mid-FETCH or mid-MEMW aborts immediately. No pulse is emitted.

Optional Feature:
- Macro: ALU_SEQ_ILLEGAL_TRAP_EN
- Defined:
  - An unknown opcode in DECODE enters the TRAP state and raises added output port illegal_op (1 bit, sticky).
  - alusrcb_sel is held at 000 and alu_op at pass-B.
  - Only reset exits TRAP.
- Undefined:
  - An unknown opcode is a NOP. Next state is FETCH, instr_done pulses, and no illegal_op port exists.

Test Plan:
- Reset then run=1, MEM_WAIT=2 → FETCH for 2 cycles with alusrcb_sel=001; ir_write and pc_write pulse on the 2nd cycle; DECODE shows sel=011.
- opcode=0x00, funct=0x22 → EXEC_R with sel=000, alu_op=001; WB; instr_done; next FETCH. 5 cycles total from FETCH entry.
- opcode=0x0C → EXEC_I with sel=100, alu_op=010; opcode=0x08 → sel=010, alu_op=000.
- opcode=0x2B then 0x23 → ADDR sel=010; MEMW mem_req=1 for 2 cycles; sw retires without WB; lw goes through WB.
- opcode=0x04 → BRANCH sel=000, alu_op=001, br_eval=1 for exactly 1 cycle.
- opcode=0x3F with the macro defined → illegal_op=1 stays high and run is ignored; reset asserted mid-MEMW → all outputs 0 asynchronously, state IDLE.
